// File: rtl/regfile_wb_arb.sv
// Two-source regfile writeback arbiter (ALU = A, LSU = B) with round-robin grant,
// a registered write port and a pending-write scoreboard for issue-stage hazard checks.
module regfile_wb_arb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [AW-1:0]        a_addr,
  input  logic [DW-1:0]        a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [AW-1:0]        b_addr,
  input  logic [DW-1:0]        b_data,
  output logic                 b_ready,
  output logic                 we,
  output logic [AW-1:0]        waddr,
  output logic [DW-1:0]        wdata,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 flush,
  input  logic                 re1,
  input  logic [AW-1:0]        raddr1,
  input  logic                 re2,
  input  logic [AW-1:0]        raddr2,
  output logic                 hazard1,
  output logic                 hazard2,
  output logic [(2**AW)-1:0]   pend
);

  localparam int NR = 2 ** AW;

  // rr_q = 0: A wins a tie; rr_q = 1: B wins a tie
  logic          rr_q, rr_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NR-1:0] pend_q, pend_d;

  logic          grant_a, grant_b, hs;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_data;

  assign grant_a = a_valid && (!b_valid || !rr_q);
  assign grant_b = b_valid && (!a_valid ||  rr_q);
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    hs      = grant_a || grant_b;
    hs_addr = grant_a ? a_addr : b_addr;
    hs_data = grant_a ? a_data : b_data;

    rr_d = rr_q;
    if (grant_a)      rr_d = 1'b1;
    else if (grant_b) rr_d = 1'b0;

    we_d    = hs && (hs_addr != '0);
    waddr_d = hs ? hs_addr : waddr_q;
    wdata_d = hs ? hs_data : wdata_q;

    // Clear on writeback, then a same-edge reservation re-sets it, then flush wins over both
    pend_d = pend_q;
    if (hs) pend_d[hs_addr] = 1'b0;
    if (rsv_valid && (rsv_addr != '0)) pend_d[rsv_addr] = 1'b1;
    if (flush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign pend    = pend_q;
  assign hazard1 = re1 && pend_q[raddr1];
  assign hazard2 = re2 && pend_q[raddr2];

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb: inputs driven and outputs sampled on the falling edge.
module tb_regfile_wb_arb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, rsv_valid, flush, re1, re2;
  logic [AW-1:0] a_addr, b_addr, rsv_addr, raddr1, raddr2;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, we, hazard1, hazard2;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [NR-1:0] pend;

  int n_chk = 0;
  int n_bad = 0;

  regfile_wb_arb #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .flush(flush),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .hazard1(hazard1), .hazard2(hazard2), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    a_valid = 0; b_valid = 0; rsv_valid = 0; flush = 0; re1 = 0; re2 = 0;
    a_addr = '0; b_addr = '0; rsv_addr = '0; raddr1 = '0; raddr2 = '0;
    a_data = '0; b_data = '0;

    @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pend", pend, 0);
    rst = 1'b1;

    // single ALU write
    a_valid = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    #1;
    chk("single_a_ready", a_ready, 1);
    chk("single_b_ready", b_ready, 0);
    step();
    a_valid = 0; a_addr = 5'd17; a_data = 32'h0BADF00D;
    chk("single_we", we, 1);
    chk("single_waddr", waddr, 5);
    chk("single_wdata", wdata, 32'hDEADBEEF);
    #1;
    chk("idle_a_ready", a_ready, 0);
    step();
    chk("single_we_off", we, 0);
    chk("single_waddr_hold", waddr, 5);

    // contention right after reset: A,B,A,B
    do_reset();
    a_valid = 1; a_addr = 1; a_data = 32'hAAAA0001;
    b_valid = 1; b_addr = 2; b_data = 32'hBBBB0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("cont%0d_a_ready", i), a_ready, (i % 2 == 0));
      chk($sformatf("cont%0d_b_ready", i), b_ready, (i % 2 == 1));
      step();
      chk($sformatf("cont%0d_we", i), we, 1);
      chk($sformatf("cont%0d_waddr", i), waddr, (i % 2 == 0) ? 1 : 2);
      chk($sformatf("cont%0d_wdata", i), wdata, (i % 2 == 0) ? 32'hAAAA0001 : 32'hBBBB0002);
    end
    a_valid = 0; b_valid = 0;
    step();
    chk("cont_we_off", we, 0);

    // scoreboard: reserve 7, query, LSU writeback to 7
    rsv_valid = 1; rsv_addr = 7;
    step();
    rsv_valid = 0;
    chk("sb_pend7", pend, 64'h80);
    re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 6;
    #1;
    chk("sb_hazard1", hazard1, 1);
    chk("sb_hazard2", hazard2, 0);
    re1 = 0;
    #1;
    chk("sb_hazard1_re0", hazard1, 0);
    re1 = 1;
    b_valid = 1; b_addr = 7; b_data = 32'h00001234;
    #1;
    chk("sb_b_ready", b_ready, 1);
    step();
    b_valid = 0;
    chk("sb_we", we, 1);
    chk("sb_waddr", waddr, 7);
    chk("sb_wdata", wdata, 32'h00001234);
    chk("sb_pend_clr", pend, 0);
    chk("sb_hazard1_clr", hazard1, 0);

    // collision: reserve 9 and write 9 on the same edge
    rsv_valid = 1; rsv_addr = 9;
    a_valid = 1; a_addr = 9; a_data = 32'h99999999;
    step();
    rsv_valid = 0; a_valid = 0;
    chk("coll_pend9", pend, 64'h200);
    chk("coll_we", we, 1);
    chk("coll_waddr", waddr, 9);
    flush = 1;
    step();
    flush = 0;
    chk("coll_flush", pend, 0);

    // x0: reservation and write to register 0
    rsv_valid = 1; rsv_addr = 0;
    b_valid = 1; b_addr = 0; b_data = 32'h12345678;
    #1;
    chk("x0_b_ready", b_ready, 1);
    step();
    rsv_valid = 0; b_valid = 0;
    chk("x0_we", we, 0);
    chk("x0_pend", pend, 0);
    raddr1 = 0;
    #1;
    chk("x0_hazard1", hazard1, 0);

    // build pend = 0xF0, then flush with a reservation to 3 and a write to 10
    for (int r = 4; r < 8; r++) begin
      rsv_valid = 1; rsv_addr = AW'(r);
      step();
    end
    rsv_valid = 0;
    chk("fl_pend_f0", pend, 64'hF0);
    flush = 1; rsv_valid = 1; rsv_addr = 3;
    a_valid = 1; a_addr = 10; a_data = 32'hCAFE000A;
    #1;
    chk("fl_a_ready", a_ready, 1);
    step();
    flush = 0; rsv_valid = 0; a_valid = 0;
    chk("fl_pend", pend, 0);
    chk("fl_we", we, 1);
    chk("fl_waddr", waddr, 10);

    // reset while a registered write is on the port
    a_valid = 1; a_addr = 12; a_data = 32'h0C0C0C0C;
    @(posedge clk);
    #2;
    a_valid = 0;
    chk("rmid_we_before", we, 1);
    rst = 1'b0;
    #1;
    chk("rmid_we", we, 0);
    chk("rmid_waddr", waddr, 0);
    chk("rmid_wdata", wdata, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("rmid_we_after1", we, 0);
    step();
    chk("rmid_we_after2", we, 0);

    // arbitration resumes with A preferred after reset
    a_valid = 1; a_addr = 3; a_data = 32'h33333333;
    b_valid = 1; b_addr = 4; b_data = 32'h44444444;
    #1;
    chk("resume_a_ready", a_ready, 1);
    chk("resume_b_ready", b_ready, 0);
    step();
    a_valid = 0; b_valid = 0;
    chk("resume_we", we, 1);
    chk("resume_waddr", waddr, 3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter DW, default 32, register data width.
REQ-002 SHALL have parameter AW, default 5, register address width (2**AW registers).
REQ-003 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have a_valid/a_addr/a_data  input  1/AW/DW  ALU writeback request.
REQ-006 SHALL have a_ready  output  1  ALU request accepted this cycle.
REQ-007 SHALL have b_valid/b_addr/b_data  input  1/AW/DW  LSU (load) writeback request.
REQ-008 SHALL have b_ready  output  1  LSU request accepted this cycle.
REQ-009 SHALL have we/waddr/wdata  output  1/AW/DW  registered regfile write port.
REQ-010 SHALL have rsv_valid/rsv_addr  input  1/AW  issue-stage destination reservation.
REQ-011 SHALL have flush  input  1  clears all reservations.
REQ-012 SHALL have re1/raddr1, re2/raddr2  input  1/AW  hazard query ports.
REQ-013 SHALL have hazard1, hazard2  output  1  queried register has pending write.
REQ-014 SHALL have pend  output  2**AW  pending-write bitmap, bit 0 always 0.

Function
REQ-015 SHALL accept at most one request per cycle; a handshake is valid&&ready on the same rising edge.
REQ-016 SHALL compute a_ready/b_ready combinationally from valids and rr pointer; ready never asserted without own valid.
REQ-017 SHALL grant the sole valid requester; when both are valid, SHALL grant the requester not granted last (round-robin); pointer updates on every grant.
REQ-018 SHALL guarantee a requester held valid waits at most 1 cycle.
REQ-019 SHALL register the accepted request: we=1, waddr, wdata appear the cycle after the handshake (latency 1), for exactly one cycle.
REQ-020 SHALL drive we=0 in any cycle following no handshake; waddr/wdata hold last values.
REQ-021 SHALL accept requests with addr 0 (ready asserted) but produce we=0 for them.
REQ-022 SHALL set pend[rsv_addr] on the edge rsv_valid=1, rsv_addr!=0.
REQ-023 SHALL clear pend[addr] on the handshake edge of a request to addr; we=1 cycle thus sees bit already 0 (regfile bypass supplies data).
REQ-024 SHALL give set priority over clear when reservation and handshake target the same addr on the same edge.
REQ-025 SHALL clear all pend bits on flush edge; flush overrides a simultaneous reservation; flush SHALL NOT cancel arbitration or the registered write.
REQ-026 SHALL drive hazardN = reN && pend[raddrN] combinationally; raddrN=0 gives 0.
REQ-027 SHALL ignore a_addr/a_data/b_addr/b_data when corresponding valid=0.

Reset
REQ-028 SHALL, while rst=0, asynchronously force we=0, waddr=0, wdata=0, pend=0, rr pointer selecting A first.
REQ-029 SHALL drop any request in flight at reset assertion; no write emitted after release for it.
REQ-030 SHALL resume arbitration on the first rising edge after rst returns to 1.

Verification
REQ-031 Single: a_valid=1,a_addr=5,a_data=0xDEADBEEF one cycle -> a_ready=1; next cycle we=1,waddr=5,wdata=0xDEADBEEF; following cycle we=0.
REQ-032 Contention: a_valid=b_valid=1 held 4 cycles after reset -> grants A,B,A,B; four consecutive we=1 cycles with matching addr/data.
REQ-033 Scoreboard: rsv 7 -> pend[7]=1, hazard1=1 for re1=1,raddr1=7; b writeback to 7 -> pend[7]=0 at we=1 cycle.
REQ-034 Collision: rsv_addr=9 and handshake addr=9 same edge -> pend[9]=1 afterwards; x0: rsv 0 and write addr 0 -> pend=0, we=0.
REQ-035 Flush: pend=0x0000_00F0, flush with rsv_addr=3 -> pend=0.
REQ-036 Reset mid-op: handshake then rst=0 before next edge -> we=0 immediately, stays 0 after release until new handshake.
